rgb565_grayscale_stream_ctrl: RTL and testbench

Frame-level controller that time-shares one external combinational rgb565Grayscale converter between the two RGB565 pixels of each 32-bit input word.
Accepts words over a valid/ready stream, sequences each pixel through the converter, and packs four 8-bit grayscale results per 32-bit output word.
Sits between the camera/DMA pixel stream and the grayscale frame-buffer writer.
Counts pixels per frame, pads the final word, and pulses done.

---
 rtl/rgb565_grayscale_stream_ctrl.sv | 154 +++++++++++++++
 tb/tb_rgb565_grayscale_stream_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb565_grayscale_stream_ctrl.sv
// rtl/rgb565_grayscale_stream_ctrl.sv - RGB565 to packed grayscale stream controller sharing one external converter
// Optional: GRAYSCALE_CTRL_THRESHOLD_EN adds threshold[7:0] and binarizes each packed byte.
module rgb565_grayscale_stream_ctrl #(
    parameter int COUNT_WIDTH = 20
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] pixelCount,
`ifdef GRAYSCALE_CTRL_THRESHOLD_EN
    input  logic [7:0]             threshold,
`endif
    output logic                   busy,
    output logic                   done,
    input  logic                   inValid,
    input  logic [31:0]            inData,
    output logic                   inReady,
    output logic                   outValid,
    output logic [31:0]            outData,
    input  logic                   outReady,
    output logic [15:0]            grayRgb565,
    input  logic [7:0]             grayValue
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CONV_LO,
        S_CONV_HI,
        S_EMIT
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [COUNT_WIDTH-1:0] remaining;
    logic [1:0]             slot;
    logic [31:0]            word;
    logic [31:0]            pack;
    logic                   done_q;
    logic [7:0]             gray_byte;
    logic                   last_pixel;

`ifdef GRAYSCALE_CTRL_THRESHOLD_EN
    logic [7:0] threshold_q;

    assign gray_byte = (grayValue >= threshold_q) ? 8'hFF : 8'h00;
`else
    assign gray_byte = grayValue;
`endif

    // The pixel being converted this cycle is the last one of the frame.
    assign last_pixel = (remaining == COUNT_WIDTH'(1));

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start && (pixelCount != '0)) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (inValid) begin
                    state_next = S_CONV_LO;
                end
            end
            S_CONV_LO: begin
                state_next = last_pixel ? S_EMIT : S_CONV_HI;
            end
            S_CONV_HI: begin
                state_next = (last_pixel || (slot == 2'd3)) ? S_EMIT : S_FETCH;
            end
            S_EMIT: begin
                if (outReady) begin
                    state_next = (remaining == '0) ? S_IDLE : S_FETCH;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        done       = done_q;
        inReady    = (state == S_FETCH);
        outValid   = (state == S_EMIT);
        outData    = pack;
        grayRgb565 = 16'h0000;
        if (state == S_CONV_LO) begin
            grayRgb565 = word[15:0];
        end else if (state == S_CONV_HI) begin
            grayRgb565 = word[31:16];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            slot      <= 2'd0;
            word      <= 32'h0;
            pack      <= 32'h0;
            done_q    <= 1'b0;
`ifdef GRAYSCALE_CTRL_THRESHOLD_EN
            threshold_q <= 8'h00;
`endif
        end else begin
            state  <= state_next;
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (pixelCount == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            remaining <= pixelCount;
                            slot      <= 2'd0;
                            pack      <= 32'h0;
                        end
`ifdef GRAYSCALE_CTRL_THRESHOLD_EN
                        threshold_q <= threshold;
`endif
                    end
                end
                S_FETCH: begin
                    if (inValid) begin
                        word <= inData;
                    end
                end
                S_CONV_LO, S_CONV_HI: begin
                    pack[{slot, 3'b000} +: 8] <= gray_byte;
                    slot                      <= slot + 2'd1;
                    if (remaining != '0) begin
                        remaining <= remaining - COUNT_WIDTH'(1);
                    end
                end
                S_EMIT: begin
                    if (outReady) begin
                        pack <= 32'h0;
                        slot <= 2'd0;
                        if (remaining == '0) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb565_grayscale_stream_ctrl.sv
// tb/tb_rgb565_grayscale_stream_ctrl.sv - randomized self-checking bench for rgb565_grayscale_stream_ctrl
module tb_rgb565_grayscale_stream_ctrl;

    localparam int CW = 20;

    logic          clock;
    logic          reset;
    logic          start;
    logic [CW-1:0] pixelCount;
    logic          busy;
    logic          done;
    logic          inValid;
    logic [31:0]   inData;
    logic          inReady;
    logic          outValid;
    logic [31:0]   outData;
    logic          outReady;
    logic [15:0]   grayRgb565;
    logic [7:0]    grayValue;
`ifdef GRAYSCALE_CTRL_THRESHOLD_EN
    logic [7:0]    threshold;
    logic [7:0]    thr_model;
`endif

    int vectors;
    int miscompares;

    logic [31:0] words [0:63];
    logic [15:0] exp_ops [$];
    logic [31:0] exp_out [$];
    int          in_taken;
    int          done_cnt;
    int          out_cnt;
    bit          saw_ffff;
    bit          zero_frame;
    logic [31:0] last_out;

    rgb565_grayscale_stream_ctrl #(.COUNT_WIDTH(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .pixelCount (pixelCount),
`ifdef GRAYSCALE_CTRL_THRESHOLD_EN
        .threshold  (threshold),
`endif
        .busy       (busy),
        .done       (done),
        .inValid    (inValid),
        .inData     (inData),
        .inReady    (inReady),
        .outValid   (outValid),
        .outData    (outData),
        .outReady   (outReady),
        .grayRgb565 (grayRgb565),
        .grayValue  (grayValue)
    );

    // Stand-in converter: luma weights 54/183/19 over 8-bit expanded channels, clamped.
    function automatic logic [7:0] conv(input logic [15:0] p);
        int r, g, b, y;
        r = int'({p[15:11], p[15:13]});
        g = int'({p[10:5], p[10:9]});
        b = int'({p[4:0], p[4:2]});
        y = (54 * r + 183 * g + 19 * b) / 255;
        if (y > 255) y = 255;
        return y[7:0];
    endfunction

    function automatic logic [7:0] model_byte(input logic [15:0] p);
`ifdef GRAYSCALE_CTRL_THRESHOLD_EN
        return (conv(p) >= thr_model) ? 8'hFF : 8'h00;
`else
        return conv(p);
`endif
    endfunction

    assign grayValue = conv(grayRgb565);

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (inValid && inReady) in_taken++;
            if (done) begin
                done_cnt++;
                check("done_while_busy", 32'(busy), 32'd0);
            end
            if (zero_frame) begin
                check("zero_busy", 32'(busy), 32'd0);
                check("zero_in_ready", 32'(inReady), 32'd0);
                check("zero_out_valid", 32'(outValid), 32'd0);
            end
            if (busy && !inReady && !outValid) begin
                if (grayRgb565 == 16'hFFFF) saw_ffff = 1'b1;
                if (exp_ops.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL operand_extra: got 0x%04h expected no conversion", grayRgb565);
                end else begin
                    check("operand", 32'(grayRgb565), 32'(exp_ops[0]));
                    void'(exp_ops.pop_front());
                end
            end else begin
                check("operand_idle", 32'(grayRgb565), 32'd0);
            end
            if (outValid) begin
                check("in_ready_in_emit", 32'(inReady), 32'd0);
                if (exp_out.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL out_extra: got 0x%08h expected no output word", outData);
                end else begin
                    check("out_data", outData, exp_out[0]);
                    if (outReady) begin
                        last_out = outData;
                        out_cnt++;
                        void'(exp_out.pop_front());
                    end
                end
            end
        end
    end

    // Entered and left at #1 after a rising edge. vmode 0 holds inValid high; rmode 0 ready,
    // 1 random, 2 stall the first five output-valid cycles.
    task automatic run_frame(input int n, input int vmode, input int rmode, input bit inject_reset);
        int nw, cyc, hold;
        logic [15:0] pix;
        logic [31:0] ow;
        nw = (n + 1) / 2;
        exp_ops.delete();
        exp_out.delete();
        for (int p = 0; p < n; p++) begin
            pix = p[0] ? words[p / 2][31:16] : words[p / 2][15:0];
            exp_ops.push_back(pix);
        end
        for (int g = 0; g < n; g += 4) begin
            ow = 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (g + k < n) ow[8 * k +: 8] = model_byte(exp_ops[g + k]);
            end
            exp_out.push_back(ow);
        end
        in_taken   = 0;
        done_cnt   = 0;
        out_cnt    = 0;
        saw_ffff   = 1'b0;
        zero_frame = (n == 0);
        start      = 1'b1;
        pixelCount = CW'(n);
        @(posedge clock);
        #1;
        start      = 1'b0;
        pixelCount = CW'($urandom);
`ifdef GRAYSCALE_CTRL_THRESHOLD_EN
        threshold  = 8'($urandom);
`endif
        cyc  = 0;
        hold = 0;
        while (done_cnt == 0 && cyc < 2000) begin
            if (inject_reset && in_taken >= 1) break;
            inValid = (in_taken < nw) && (vmode == 0 || $urandom_range(0, 1) == 1);
            inData  = (in_taken < nw) ? words[in_taken] : $urandom;
            case (rmode)
                0: outReady = 1'b1;
                1: outReady = ($urandom_range(0, 2) != 0);
                default: begin
                    if (outValid) hold++;
                    outReady = (hold > 5);
                end
            endcase
            @(posedge clock);
            #1;
            cyc++;
        end
        inValid = 1'b0;
        if (inject_reset) begin
            check("reset_point_reached", 32'(in_taken), 32'd1);
            reset = 1'b1;
            repeat (2) @(posedge clock);
            exp_ops.delete();
            exp_out.delete();
            #1;
            reset = 1'b0;
            check("mid_rst_busy", 32'(busy), 32'd0);
            check("mid_rst_done", 32'(done), 32'd0);
            check("mid_rst_in_ready", 32'(inReady), 32'd0);
            check("mid_rst_out_valid", 32'(outValid), 32'd0);
            check("mid_rst_out_data", outData, 32'd0);
            check("mid_rst_operand", 32'(grayRgb565), 32'd0);
            repeat (4) @(posedge clock);
            #1;
            check("mid_rst_no_done", 32'(done_cnt), 32'd0);
        end else begin
            repeat (3) @(posedge clock);
            #1;
            check("frame_done_count", 32'(done_cnt), 32'd1);
            check("ops_left", 32'(exp_ops.size()), 32'd0);
            check("outs_left", 32'(exp_out.size()), 32'd0);
            check("out_words", 32'(out_cnt), 32'((n + 3) / 4));
            check("in_words", 32'(in_taken), 32'(nw));
            check("busy_after", 32'(busy), 32'd0);
        end
        zero_frame = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        start       = 1'b0;
        pixelCount  = '0;
        inValid     = 1'b0;
        inData      = 32'h0;
        outReady    = 1'b0;
        zero_frame  = 1'b0;
        last_out    = 32'h0;
`ifdef GRAYSCALE_CTRL_THRESHOLD_EN
        threshold   = 8'd100;
        thr_model   = 8'd100;
`endif
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_in_ready", 32'(inReady), 32'd0);
        check("rst_out_valid", 32'(outValid), 32'd0);
        check("rst_out_data", outData, 32'd0);
        check("rst_operand", 32'(grayRgb565), 32'd0);

        words[0] = 32'hFFFF0000;
        words[1] = 32'h001F07E0;
`ifdef GRAYSCALE_CTRL_THRESHOLD_EN
        threshold = 8'd100;
`endif
        run_frame(4, 0, 0, 0);
`ifdef GRAYSCALE_CTRL_THRESHOLD_EN
        check("pin_four_px", last_out, 32'h00FFFF00);
`else
        check("pin_four_px", last_out, 32'h13B7FF00);
`endif

        words[0] = 32'h07E0F800;
        words[1] = 32'hFFFF001F;
`ifdef GRAYSCALE_CTRL_THRESHOLD_EN
        threshold = 8'd100;
`endif
        run_frame(3, 0, 0, 0);
`ifdef GRAYSCALE_CTRL_THRESHOLD_EN
        check("pin_three_px", last_out, 32'h0000FF00);
`else
        check("pin_three_px", last_out, 32'h0013B736);
`endif
        check("three_px_handshakes", 32'(in_taken), 32'd2);
        check("three_px_no_ffff", 32'(saw_ffff), 32'd0);

        words[0] = 32'hFFFF0000;
        words[1] = 32'h001F07E0;
`ifdef GRAYSCALE_CTRL_THRESHOLD_EN
        threshold = 8'd100;
`endif
        run_frame(4, 0, 2, 0);
`ifdef GRAYSCALE_CTRL_THRESHOLD_EN
        check("pin_stalled", last_out, 32'h00FFFF00);
`else
        check("pin_stalled", last_out, 32'h13B7FF00);
`endif

        run_frame(0, 0, 0, 0);

        for (int i = 0; i < 4; i++) words[i] = $urandom;
        run_frame(8, 0, 0, 1);

        words[0] = 32'hFFFF0000;
        words[1] = 32'h001F07E0;
`ifdef GRAYSCALE_CTRL_THRESHOLD_EN
        threshold = 8'd100;
`endif
        run_frame(4, 0, 0, 0);
`ifdef GRAYSCALE_CTRL_THRESHOLD_EN
        check("pin_after_reset", last_out, 32'h00FFFF00);
`else
        check("pin_after_reset", last_out, 32'h13B7FF00);
`endif

        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < 16; i++) words[i] = $urandom;
`ifdef GRAYSCALE_CTRL_THRESHOLD_EN
            threshold = 8'($urandom);
            thr_model = threshold;
`endif
            run_frame((f < 2) ? f + 1 : $urandom_range(1, 30), $urandom_range(0, 1),
                      $urandom_range(0, 1), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

`ifdef GRAYSCALE_CTRL_THRESHOLD_EN
    // The bench model uses the threshold that was presented when start was taken.
    always @(posedge clock) begin
        if (start && !busy) thr_model <= threshold;
    end
`endif

endmodule
